mul_cplx_scale: RTL and testbench

MUL_CPLX_SCALE -- requirements
Module: mul_cplx_scale

---
 rtl/mul_cplx_scale.sv | 108 ++++++++++
 tb/tb_mul_cplx_scale.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mul_cplx_scale.sv
// Serial shift-and-add scaling of a signed complex sample by an unsigned scalar.
// Optional round-half-up output when MUL_CPLX_SCALE_RND_EN is defined.
module mul_cplx_scale #(
  parameter int unsigned DW = 16,
  parameter int unsigned ZW = 8,
  parameter int unsigned OW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] dix,
  input  logic signed [DW-1:0] diy,
  input  logic        [ZW-1:0] diz,
  input  logic                 iv,
  output logic                 rdy,
  output logic signed [OW-1:0] dox,
  output logic signed [OW-1:0] doy,
  output logic                 ov
);

  localparam int unsigned PW = DW + ZW;
  localparam int unsigned K  = PW - OW;
  localparam int unsigned CW = $clog2(ZW);

`ifdef MUL_CPLX_SCALE_RND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] xs, ys;
  logic [PW-1:0] accx, accy;
  logic [ZW-1:0] zs;
  logic [CW-1:0] cnt;

  logic [PW-1:0] rnd_c;
  logic [PW-1:0] sumx_c, sumy_c;
  logic [PW-1:0] rndx_c, rndy_c;
  logic [OW-1:0] outx_c, outy_c;

  // Half-LSB bias of the kept field; zero when truncating or nothing is dropped
  if (RND_EN && (K > 0)) begin : g_rnd
    assign rnd_c = PW'(1) << (K - 1);
  end else begin : g_trn
    assign rnd_c = '0;
  end

  // Partial-product step: add the shifted multiplicand when the current diz bit is set
  always_comb begin
    sumx_c = accx + (zs[0] ? xs : '0);
    sumy_c = accy + (zs[0] ? ys : '0);
    rndx_c = sumx_c + rnd_c;
    rndy_c = sumy_c + rnd_c;
    outx_c = OW'(rndx_c >> K);
    outy_c = OW'(rndy_c >> K);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy   <= 1'b1;
      ov    <= 1'b0;
      dox   <= '0;
      doy   <= '0;
      xs    <= '0;
      ys    <= '0;
      zs    <= '0;
      accx  <= '0;
      accy  <= '0;
      cnt   <= '0;
    end else begin
      ov <= 1'b0;
      case (state)
        IDLE: begin
          if (iv) begin
            xs    <= {{ZW{dix[DW-1]}}, dix};
            ys    <= {{ZW{diy[DW-1]}}, diy};
            zs    <= diz;
            accx  <= '0;
            accy  <= '0;
            cnt   <= '0;
            rdy   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          accx <= sumx_c;
          accy <= sumy_c;
          xs   <= xs << 1;
          ys   <= ys << 1;
          zs   <= zs >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(ZW - 1)) begin
            dox   <= outx_c;
            doy   <= outy_c;
            ov    <= 1'b1;
            rdy   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_cplx_scale.sv
// Scoreboard bench for mul_cplx_scale: arithmetic reference model, queue of
// expected results, monitor comparing every ov pulse.
module tb_mul_cplx_scale;

  localparam int DW = 16;
  localparam int ZW = 8;
  localparam int OW = 20;
  localparam int K  = DW + ZW - OW;

`ifdef MUL_CPLX_SCALE_RND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] dix, diy;
  logic        [ZW-1:0] diz;
  logic                 iv;
  logic                 rdy, ov;
  logic signed [OW-1:0] dox, doy;

  mul_cplx_scale #(.DW(DW), .ZW(ZW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .dix(dix), .diy(diy), .diz(diz), .iv(iv),
    .rdy(rdy), .dox(dox), .doy(doy), .ov(ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x;
    longint y;
    int     acc_edge;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = -100;
  logic rst_q    = 1'b1;
  bit   started  = 1'b0;
  logic signed [OW-1:0] prev_x, prev_y;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exact product, optional half-LSB bias, then floor division by 2^K
  function automatic longint ref_scale(input longint d, input longint z);
    longint p;
    p = d * z;
    if (RND && K > 0) p = p + (longint'(1) << (K - 1));
    return p >>> K;
  endfunction

  function automatic bit model_idle();
    return cyc >= last_acc + ZW;
  endfunction

  // Called just after a rising edge; drives one cycle of stimulus
  task automatic step(input bit v, input logic signed [DW-1:0] x,
                      input logic signed [DW-1:0] y, input logic [ZW-1:0] z);
    exp_t e;
    iv = v; dix = x; diy = y; diz = z;
    chk("rdy", longint'(rdy), longint'(model_idle()));
    if (v && model_idle()) begin
      e.x = ref_scale(longint'(x), longint'(z));
      e.y = ref_scale(longint'(y), longint'(z));
      e.acc_edge = cyc + 1;
      sb.push_back(e);
      last_acc = cyc + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    iv  = 1'b1;
    dix = DW'($urandom); diy = DW'($urandom); diz = ZW'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    last_acc = -100;
    chk("rst_rdy", longint'(rdy), 1);
    chk("rst_ov", longint'(ov), 0);
    chk("rst_dox", longint'(dox), 0);
    chk("rst_doy", longint'(doy), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(1'b0, DW'($urandom), DW'($urandom), ZW'($urandom));
  endtask

  // Monitor: pop and compare on every ov, check hold and single-pulse behaviour
  always @(negedge clk) begin
    exp_t e;
    if (started && rst_q !== 1'b1) begin
      if (ov === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ov: got ov=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("dox", longint'(dox), e.x);
          chk("doy", longint'(doy), e.y);
          chk("latency", longint'(cyc), longint'(e.acc_edge + ZW));
        end
      end else begin
        chk("hold_dox", longint'(dox), longint'(prev_x));
        chk("hold_doy", longint'(doy), longint'(prev_y));
      end
    end
    prev_x = dox;
    prev_y = doy;
  end

  initial begin
    logic signed [DW-1:0] x;
    rst = 1'b1; iv = 1'b0; dix = '0; diy = '0; diz = '0;
    @(posedge clk); #1;
    do_reset(2);
    started = 1'b1;

    // Directed corners
    step(1'b1, 16'sd1000, -16'sd1000, 8'd255);      idle_cycles(ZW);
    step(1'b1, -16'sd32768, 16'sd32767, 8'd255);    idle_cycles(ZW);
    step(1'b1, 16'sd12345, -16'sd321, 8'd0);        idle_cycles(ZW);
    step(1'b1, -16'sd1, -16'sd1, 8'd1);             idle_cycles(ZW);
    step(1'b1, 16'sd32767, -16'sd32768, 8'd128);    idle_cycles(ZW + 3);

    // Sustained iv with incrementing dix: one result per ZW+1 clocks
    x = 16'sd100;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, x, -x, ZW'($urandom));
      x = x + 16'sd7;
    end
    idle_cycles(ZW + 2);

    // Reset four clocks after acceptance aborts the sample
    step(1'b1, 16'sd555, 16'sd666, 8'd200);
    idle_cycles(3);
    do_reset(1);
    idle_cycles(ZW + 2);
    step(1'b1, 16'sd555, 16'sd666, 8'd200);
    idle_cycles(ZW + 2);

    // Randomized traffic with occasional extremes and rare resets
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        do_reset(int'($urandom_range(1, 2)));
      end else if (r < 6) begin
        step(1'b1, (r[0] ? -16'sd32768 : 16'sd32767), (r[1] ? 16'sd32767 : -16'sd32768),
             (r[2] ? 8'd255 : 8'd0));
      end else begin
        step(r < 85, DW'($urandom), DW'($urandom), ZW'($urandom));
      end
    end
    idle_cycles(ZW + 4);

    chk("sb_empty", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
